// File: rtl/spart_bus_arbiter_if.sv
// Requester-side handshake plus SPART control/status signals shared by the
// arbiter (slave view) and its environment (master view: clients and SPART).
interface spart_bus_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   we;
  logic [2*NREQ-1:0] addr;
  logic [8*NREQ-1:0] wdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              err;
  logic [7:0]        rdata;
  logic              busy;
  logic              iocs;
  logic              iorw;
  logic [1:0]        ioaddr;
  logic              rda;
  logic              tbr;

  modport master (
    output req, we, addr, wdata, rda, tbr,
    input  gnt, done, err, rdata, busy, iocs, iorw, ioaddr
  );

  modport slave (
    input  req, we, addr, wdata, rda, tbr,
    output gnt, done, err, rdata, busy, iocs, iorw, ioaddr
  );
endinterface

// File: rtl/spart_bus_arbiter.sv
// Round-robin arbiter sharing the SPART register bus among NREQ clients.
// One transaction at a time: IDLE -> WAIT (tbr/rda gating, timeout) ->
// ACCESS (single bus cycle) -> DONE (completion pulse).
module spart_bus_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1023
) (
  input logic               clk,
  input logic               rst,
  spart_bus_arbiter_if.slave bus,
  inout wire  [7:0]         databus
);

  localparam int          SW = $clog2(NREQ);
  localparam int          CW = $clog2(TIMEOUT + 1);
  localparam int unsigned NU = NREQ;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

  state_t        state;
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] sel_q;
  logic [SW-1:0] sel_c;
  logic [SW-1:0] idx;
  logic          any_req;
  logic          we_q;
  logic [1:0]    addr_q;
  logic [7:0]    wdata_q;
  logic          err_pending;
  logic [CW-1:0] wait_cnt;
  logic          ready;

  // Pick the first requester at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    sel_c   = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      idx = SW'((32'(rr_ptr) + i) % NU);
      if (!any_req && bus.req[idx]) begin
        any_req = 1'b1;
        sel_c   = idx;
      end
    end
  end

  // Data-register accesses wait on the SPART buffer flags; others proceed at once.
  always_comb begin
    ready = 1'b1;
    if (addr_q == 2'b00) ready = we_q ? bus.tbr : bus.rda;
  end

  // Output decode from the registered state; grant is the only path from req.
  always_comb begin
    bus.gnt    = (!rst && state == IDLE && any_req) ? (ONE << sel_c) : '0;
    bus.done   = (state == DONE) ? (ONE << sel_q) : '0;
    bus.err    = (state == DONE) && err_pending;
    bus.busy   = (state != IDLE);
    bus.iocs   = (state == ACCESS);
    bus.iorw   = (state == ACCESS) ? ~we_q : 1'b1;
    bus.ioaddr = (state == ACCESS) ? addr_q : 2'b00;
  end

  // The arbiter drives the data bus only during a write access cycle.
  assign databus = (state == ACCESS && we_q) ? wdata_q : 'z;

  // Transaction sequencer, command latch, wait timer and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_pending <= 1'b0;
      wait_cnt    <= '0;
      bus.rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            sel_q       <= sel_c;
            we_q        <= bus.we[sel_c];
            addr_q      <= bus.addr[{sel_c, 1'b0} +: 2];
            wdata_q     <= bus.wdata[{sel_c, 3'b000} +: 8];
            wait_cnt    <= '0;
            err_pending <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (ready) begin
            state <= ACCESS;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            err_pending <= 1'b1;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ACCESS: begin
          if (!we_q) bus.rdata <= databus;
          state <= DONE;
        end
        default: begin
          rr_ptr <= (sel_q == SW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
